// File: rtl/tri_bus_pkg.sv
// Shared definitions for the four-source tristate bus arbiter:
// state encoding, source count, select width and the grant decode.
package tri_bus_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_OWN  = 2'd2;
    localparam logic [1:0] ST_TURN = 2'd3;

    // One-hot grant vector for a given select value.
    function automatic logic [NUM_SRC-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
        sel_onehot = NUM_SRC'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit found scanning
// upward (with wrap) from the source after the most recent owner.
module rr_pick
    import tri_bus_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   idx,
    output logic               any
);

    logic [SEL_W-1:0] w_cand;

    // Scan from farthest to nearest so the nearest set bit wins; the
    // 2-bit add wraps, and k=NUM_SRC lands on last itself (lowest priority).
    always_comb begin
        idx    = '0;
        any    = |req;
        w_cand = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            w_cand = last + SEL_W'(k);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin arbiter driving the select/enable of the shared tristate bus,
// with a turnaround cycle on every ownership change and a hold limit.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] req,
    output logic               s0,
    output logic               s1,
    output logic               e,
    output logic [NUM_SRC-1:0] gnt,
    output logic               timeout
);

    localparam int unsigned     HOLD_W    = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [1:0]         r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_last;
    logic [HOLD_W-1:0]  r_hold;
    logic               r_e;
    logic [NUM_SRC-1:0] r_gnt;
    logic               r_timeout;

    logic [1:0]         w_state_nxt;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   w_last_nxt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic               w_e_nxt;
    logic [NUM_SRC-1:0] w_gnt_nxt;
    logic               w_timeout_nxt;

    logic [SEL_W-1:0]   w_pick;
    logic               w_any;
    logic               w_req_sel;
    logic               w_at_limit;

    rr_pick u_pick (
        .req  (req),
        .last (r_last),
        .idx  (w_pick),
        .any  (w_any)
    );

    assign w_req_sel  = req[r_sel];
    assign w_at_limit = (r_hold == HOLD_LAST);

    // Next-state and next-output logic; outputs are registered from these.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        w_timeout_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_sel_nxt   = w_pick;
                    w_state_nxt = ST_ARM;
                end
            end
            ST_ARM: begin
                if (w_req_sel) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_OWN;
                end else begin
                    w_last_nxt  = r_sel;
                    w_state_nxt = ST_TURN;
                end
            end
            ST_OWN: begin
                // A release coinciding with the limit counts as a normal release.
                if (!w_req_sel || w_at_limit) begin
                    w_last_nxt    = r_sel;
                    w_timeout_nxt = w_req_sel;
                    w_state_nxt   = ST_TURN;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            ST_TURN: begin
                if (w_any) begin
                    w_sel_nxt   = w_pick;
                    w_state_nxt = ST_ARM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_e_nxt   = (w_state_nxt == ST_OWN);
        w_gnt_nxt = ((w_state_nxt == ST_ARM) || (w_state_nxt == ST_OWN))
                    ? sel_onehot(w_sel_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_last    <= SEL_W'(NUM_SRC - 1);
            r_hold    <= '0;
            r_e       <= 1'b0;
            r_gnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_e       <= w_e_nxt;
            r_gnt     <= w_gnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign s0      = r_sel[0];
    assign s1      = r_sel[1];
    assign e       = r_e;
    assign gnt     = r_gnt;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Self-checking bench for tri_bus_arbiter: directed scenarios plus random
// request traffic compared cycle by cycle against a behavioural model.
module tb_tri_bus_arbiter;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       s0, s1, e, timeout;
    logic [3:0] gnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .s0      (s0),
        .s1      (s1),
        .e       (e),
        .gnt     (gnt),
        .timeout (timeout)
    );

    // Behavioural model: who owns the bus, in which phase, and for how long.
    typedef enum int {M_IDLE, M_ARM, M_OWN, M_TURN} mphase_t;
    mphase_t m_phase;
    int      m_owner;
    int      m_last;
    int      m_cnt;
    bit      m_tmo;

    function automatic int pick(input logic [3:0] r, input int last);
        int i;
        for (int k = 1; k <= 4; k++) begin
            i = (last + k) % 4;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic int gidx(input logic [3:0] g);
        case (g)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] m_exp();
        logic [3:0] g;
        g = (m_phase == M_ARM || m_phase == M_OWN) ? 4'(1 << m_owner) : 4'b0000;
        return {2'(m_owner), (m_phase == M_OWN), g, m_tmo};
    endfunction

    function automatic logic [7:0] obs();
        return {s1, s0, e, gnt, timeout};
    endfunction

    task automatic m_step(input bit r, input logic [3:0] rq);
        if (r) begin
            m_phase = M_IDLE; m_owner = 0; m_last = 3; m_cnt = 0; m_tmo = 0;
            return;
        end
        m_tmo = 0;
        case (m_phase)
            M_IDLE: if (rq != 0) begin m_owner = pick(rq, m_last); m_phase = M_ARM; end
            M_ARM: begin
                if (rq[m_owner]) begin m_phase = M_OWN; m_cnt = 1; end
                else begin m_last = m_owner; m_phase = M_TURN; end
            end
            M_OWN: begin
                if (!rq[m_owner]) begin
                    m_last = m_owner; m_phase = M_TURN;
                end else if (m_cnt == MAX_HOLD) begin
                    m_last = m_owner; m_phase = M_TURN; m_tmo = 1;
                end else begin
                    m_cnt++;
                end
            end
            default: begin
                if (rq != 0) begin m_owner = pick(rq, m_last); m_phase = M_ARM; end
                else m_phase = M_IDLE;
            end
        endcase
    endtask

    task automatic tick(input bit r, input logic [3:0] rq);
        @(negedge clk);
        rst = r;
        req = rq;
        @(posedge clk);
        m_step(r, rq);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            tick(1'b1, 4'b1111);
            checks++;
            if (obs() !== 8'h00) begin
                errors++;
                $display("FAIL reset_outs: got %b expected 00000000", obs());
            end
        end
    endtask

    task automatic test_single();
        logic [3:0] seq [6];
        int ecnt;
        seq = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        ecnt = 0;
        tick(1'b1, 4'b0000);
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, seq[c]);
            checks++;
            if (obs() !== m_exp()) begin
                errors++;
                $display("FAIL single_cycle%0d: got %b expected %b", c, obs(), m_exp());
            end
            if (e) ecnt++;
            if (c == 0) begin
                checks++;
                if (gnt !== 4'b0100 || {s1, s0} !== 2'd2 || e !== 1'b0) begin
                    errors++;
                    $display("FAIL single_arm: got gnt=%b sel=%0d e=%b expected 0100/2/0", gnt, {s1, s0}, e);
                end
            end
            if (c == 1) begin
                checks++;
                if (e !== 1'b1) begin
                    errors++;
                    $display("FAIL single_latency: got e=%b expected 1", e);
                end
            end
        end
        checks++;
        if (ecnt != 3) begin
            errors++;
            $display("FAIL single_own_len: got %0d expected 3", ecnt);
        end
    endtask

    task automatic test_round_robin();
        int         got[$];
        int         exp_order[5];
        logic       prev_e;
        logic [3:0] prev_gnt;
        logic [3:0] drv;
        exp_order = '{0, 1, 2, 3, 0};
        prev_e = 1'b0;
        prev_gnt = 4'b0000;
        tick(1'b1, 4'b0000);
        for (int c = 0; c < 100 && got.size() < 5; c++) begin
            drv = 4'b1111;
            if (m_phase == M_OWN && m_cnt == 2) drv[m_owner] = 1'b0;
            tick(1'b0, drv);
            checks++;
            if (obs() !== m_exp()) begin
                errors++;
                $display("FAIL rr_cycle%0d: got %b expected %b", c, obs(), m_exp());
            end
            if (e && !prev_e) got.push_back(gidx(gnt));
            if (e && prev_e) begin
                checks++;
                if (gnt !== prev_gnt) begin
                    errors++;
                    $display("FAIL rr_overlap: got gnt=%b after %b with e high, expected unchanged", gnt, prev_gnt);
                end
            end
            prev_e = e;
            prev_gnt = gnt;
        end
        checks++;
        if (got.size() < 5) begin
            errors++;
            $display("FAIL rr_budget: got %0d grants expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] != exp_order[i]) begin
                    errors++;
                    $display("FAIL rr_order%0d: got %0d expected %0d", i, got[i], exp_order[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int   run_own[8];
        int   run_len[8];
        int   nruns;
        int   ntmo;
        logic prev_e;
        nruns = 0; ntmo = 0; prev_e = 1'b0;
        tick(1'b1, 4'b0000);
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 4'b0011);
            checks++;
            if (obs() !== m_exp()) begin
                errors++;
                $display("FAIL tmo_cycle%0d: got %b expected %b", c, obs(), m_exp());
            end
            if (e && !prev_e && nruns < 8) begin
                run_own[nruns] = gidx(gnt); run_len[nruns] = 1; nruns++;
            end else if (e && prev_e && nruns > 0) begin
                run_len[nruns-1]++;
            end
            if (timeout) begin
                ntmo++;
                checks++;
                if (e !== 1'b0 || gnt !== 4'b0000 || !prev_e) begin
                    errors++;
                    $display("FAIL tmo_in_turn: got e=%b gnt=%b prev_e=%b expected 0/0000/1", e, gnt, prev_e);
                end
            end
            prev_e = e;
        end
        checks++;
        if (ntmo != 3) begin
            errors++;
            $display("FAIL tmo_count: got %0d expected 3", ntmo);
        end
        checks++;
        if (nruns < 3) begin
            errors++;
            $display("FAIL tmo_runs: got %0d expected at least 3", nruns);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (run_own[i] != (i % 2) || run_len[i] != MAX_HOLD) begin
                    errors++;
                    $display("FAIL tmo_run%0d: got src %0d len %0d expected src %0d len %0d",
                             i, run_own[i], run_len[i], i % 2, MAX_HOLD);
                end
            end
        end
    endtask

    task automatic test_withdraw();
        logic [3:0] seq [7];
        seq = '{4'b0010, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 4'b0000, 4'b0000};
        tick(1'b1, 4'b0000);
        for (int c = 0; c < 7; c++) begin
            tick(1'b0, seq[c]);
            checks++;
            if (obs() !== m_exp()) begin
                errors++;
                $display("FAIL wd_cycle%0d: got %b expected %b", c, obs(), m_exp());
            end
            checks++;
            if (e !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL wd_no_enable%0d: got e=%b timeout=%b expected 0/0", c, e, timeout);
            end
            if (c == 0 || c == 3) begin
                checks++;
                if (gnt !== ((c == 0) ? 4'b0010 : 4'b0100)) begin
                    errors++;
                    $display("FAIL wd_gnt%0d: got %b expected %b", c, gnt, (c == 0) ? 4'b0010 : 4'b0100);
                end
            end
        end
    endtask

    task automatic test_reset_mid_own();
        tick(1'b1, 4'b0000);
        tick(1'b0, 4'b1000);
        tick(1'b0, 4'b1000);
        tick(1'b0, 4'b1000);
        checks++;
        if (e !== 1'b1 || gnt !== 4'b1000) begin
            errors++;
            $display("FAIL rmo_setup: got e=%b gnt=%b expected 1/1000", e, gnt);
        end
        tick(1'b1, 4'b1000);
        checks++;
        if (obs() !== 8'h00) begin
            errors++;
            $display("FAIL rmo_reset: got %b expected 00000000", obs());
        end
        tick(1'b0, 4'b1001);
        checks++;
        if (gnt !== 4'b0001 || {s1, s0} !== 2'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL rmo_first_grant: got gnt=%b sel=%0d e=%b expected 0001/0/0", gnt, {s1, s0}, e);
        end
        checks++;
        if (obs() !== m_exp()) begin
            errors++;
            $display("FAIL rmo_model: got %b expected %b", obs(), m_exp());
        end
    endtask

    task automatic test_random();
        logic [3:0] rq;
        bit         r;
        rq = 4'b0000;
        tick(1'b1, 4'b0000);
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            tick(r, rq);
            checks++;
            if (obs() !== m_exp()) begin
                errors++;
                $display("FAIL rand_cycle%0d: got %b expected %b", c, obs(), m_exp());
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        m_phase = M_IDLE; m_owner = 0; m_last = 3; m_cnt = 0; m_tmo = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_withdraw();
        test_reset_mid_own();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
